// File: rtl/mux_arbiter_pkg.sv
// ============================================================================
// Module   : mux_arbiter_pkg
// Purpose  : Shared index-width helpers and lock state type for mux/demux blocks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arbiter_pkg;

  localparam int C_MAX_ONEHOT_W = 64;

  typedef enum logic [0:0] {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lockState_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit index port.
  function automatic int selWidth(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  function automatic int unsigned oneHotToIdx(input logic [C_MAX_ONEHOT_W-1:0] oneHot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < C_MAX_ONEHOT_W; i++) begin
      if (oneHot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant starting after ptr, with optional
//            grant lock (MUX_ARBITER_LOCK_EN)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = selWidth(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
`ifdef MUX_ARBITER_LOCK_EN
  input  logic                lock,
  input  logic [SEL_W-1:0]    lockIdx,
`endif
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grantIdx
);

  logic w_found;

  // Two passes: channels above ptr first, then wrap around to 0..ptr.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (!w_found && req[j] && (SEL_W'(j) > ptr)) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int j = 0; j < CHANNELS; j++) begin
      if (!w_found && req[j] && (SEL_W'(j) <= ptr)) begin
        grant[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
`ifdef MUX_ARBITER_LOCK_EN
    // A locked channel owns the grant even while its request is low.
    if (lock) begin
      for (int j = 0; j < CHANNELS; j++) begin
        grant[j] = (SEL_W'(j) == lockIdx);
      end
    end
`endif
  end

  assign grantIdx = SEL_W'(oneHotToIdx(C_MAX_ONEHOT_W'(grant)));

endmodule

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ============================================================================
// Module   : mux_arbiter
// Purpose  : Registered N-channel round-robin mux with valid/ready handshake.
//            Optional packet lock via macro MUX_ARBITER_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = selWidth(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef MUX_ARBITER_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic                r_outValid;
  logic [WIDTH-1:0]    r_outData;
  logic [SEL_W-1:0]    r_outSel;
  logic [SEL_W-1:0]    r_ptr;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_grantIdx;
  logic [WIDTH-1:0]    w_grantData;
  logic                w_load;
  logic                w_xfer;
  logic                w_ptrUpdate;

  assign w_load   = !r_outValid || out_ready;
  assign in_ready = w_grant & {CHANNELS{w_load}};
  assign w_xfer   = |(in_valid & in_ready);

`ifdef MUX_ARBITER_LOCK_EN
  lockState_t       r_lockState;
  lockState_t       w_lockStateNext;
  logic [SEL_W-1:0] r_lockIdx;
  logic [SEL_W-1:0] w_lockIdxNext;
  logic             w_lastBeat;

  assign w_lastBeat = |(in_last & w_grant);

  // Pointer only advances when a packet completes, so locked beats keep fairness.
  always_comb begin
    w_lockStateNext = r_lockState;
    w_lockIdxNext   = r_lockIdx;
    w_ptrUpdate     = 1'b0;
    if (w_xfer) begin
      if (w_lastBeat) begin
        w_lockStateNext = LOCK_OPEN;
        w_ptrUpdate     = 1'b1;
      end else begin
        w_lockStateNext = LOCK_HELD;
        w_lockIdxNext   = w_grantIdx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lockState <= LOCK_OPEN;
      r_lockIdx   <= '0;
    end else begin
      r_lockState <= w_lockStateNext;
      r_lockIdx   <= w_lockIdxNext;
    end
  end
`else
  assign w_ptrUpdate = w_xfer;
`endif

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rrArbiter (
    .req      (in_valid),
    .ptr      (r_ptr),
`ifdef MUX_ARBITER_LOCK_EN
    .lock     (r_lockState == LOCK_HELD),
    .lockIdx  (r_lockIdx),
`endif
    .grant    (w_grant),
    .grantIdx (w_grantIdx)
  );

  always_comb begin
    w_grantData = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (w_grant[j]) w_grantData = in_data[j*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSel   <= '0;
      r_ptr      <= SEL_W'(CHANNELS - 1);
    end else if (w_load) begin
      r_outValid <= w_xfer;
      if (w_xfer) begin
        r_outData <= w_grantData;
        r_outSel  <= w_grantIdx;
      end
      if (w_ptrUpdate) r_ptr <= w_grantIdx;
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_sel   = r_outSel;

endmodule

`default_nettype wire

// File: doc/mux_arbiter.md
# mux_arbiter

Registered N-channel, W-bit multiplexer with valid/ready handshaking and round-robin channel selection. It is the sequential, parametrised successor of the single-bit 2:1 mux: instead of an external select, it chooses among requesting channels fairly and registers the winning word. It sits wherever several producers share one consumer, for example memory-port sharing or merging instruction and data fetch streams.

## Interface
- `WIDTH`, default 16: data bits per channel.
- `CHANNELS`, default 4: number of input channels; must be ≥1.
- `SEL_W`, derived as max(1, clog2(CHANNELS)): width of the channel index. Not user-overridable.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, CHANNELS: per-channel request.
- `in_data`, input, CHANNELS*WIDTH: flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`, output, CHANNELS: per-channel accept; at most one bit is high.
- `out_valid`, output, 1: registered output word is valid.
- `out_data`, output, WIDTH: registered selected word.
- `out_sel`, output, SEL_W: index of the channel that produced `out_data`.
- `out_ready`, input, 1: consumer accepts the output word.

## Operation
- Output stage: one register holding `out_valid`, `out_data` and `out_sel`.
- `load = !out_valid || out_ready` (register empty or being drained).
- Grant: one-hot combinational grant. Search starts at `ptr+1` mod CHANNELS and selects the first channel with `in_valid` high.
- `in_ready[i] = grant[i] && load`.
- A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- On a transfer:
  - `out_data` takes channel i's data.
  - `out_sel` takes i.
  - `out_valid` goes to 1.
  - `ptr` takes i.
- When `load` is high and no channel transfers, `out_valid` goes to 0 and `out_data`/`out_sel` hold their values.
- When `load` is low, all registers hold.
- Fairness: a continuously requesting channel waits at most CHANNELS-1 accepted transfers.
- Producers must hold `in_valid` and `in_data` stable until accepted. The block does not check this.
- CHANNELS=1: the grant is always channel 0 and `out_sel` is always 0.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0.
  - `ptr` = CHANNELS-1, so channel 0 has first priority.
  - Lock state is cleared.
- Reset mid-operation discards any held word immediately, without waiting for a clock edge.
- Latency: a word accepted at edge k is on `out_data` with `out_valid` high after edge k.
- Throughput: one word per cycle while `out_ready` stays high.
- Combinational paths: `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_data` to the outputs.
- Back-pressure: with `out_valid=1` and `out_ready=0`, all of `in_ready` is 0 and the outputs are stable.
- Simultaneous drain and fill: in the same cycle as `out_ready`, a new word loads. `out_valid` stays 1 with no bubble.

## Configuration
- Macro: `MUX_ARBITER_LOCK_EN`.
- When defined:
  - Adds an input port `in_last`, CHANNELS bits wide.
  - A transfer with `in_last[i]=0` locks the grant to channel i.
  - While locked, only channel i can be granted, even if its `in_valid` is low; other channels stall.
  - The lock releases on a transfer with `in_last[i]=1`.
  - `ptr` updates only on the releasing transfer.
- When not defined:
  - No `in_last` port.
  - Arbitration is re-run every beat.

## Structure
- Shared package or header `mux_defs.vh`, holding:
  - the clog2 function;
  - the SEL_W derivation;
  - the one-hot-to-index conversion function.
  - These are reusable by later mux/demux blocks.
- Sub-module `rr_arbiter`:
  - parameter CHANNELS;
  - inputs: `req`, `ptr`, and optionally `lock`/`lock_idx`;
  - outputs: one-hot `grant` and `grant_idx`;
  - purely combinational.
- The top level holds `ptr`, the lock state and the output register.

## Test plan
1. Reset: assert `reset_n=0` mid-stream with `out_valid=1` → `out_valid`, `out_data` and `out_sel` are 0 immediately; after release, channel 0 wins first.
2. Round robin: CHANNELS=4, all `in_valid=1`, `out_ready=1`, data = 0xA0+i → `out_sel` sequence is 0,1,2,3,0 with no idle cycles.
3. Back-pressure: `out_ready=0` for 3 cycles with a word held → `out_data` stable and `in_ready` = 0000; raising `out_ready` gives the next word the following cycle with no bubble.
4. Sparse requests: only channel 2 valid, then channel 1 → `out_sel` = 2 then 1; a single requester is granted in one cycle.
5. Lock (with `MUX_ARBITER_LOCK_EN`): channel 1 sends 3 beats with `in_last` = 0,0,1 while channel 0 requests → `out_sel` = 1,1,1,0.
6. CHANNELS=1, WIDTH=8: a stream of 0x00..0xFF passes in order with `out_sel` = 0.
